pedo_cmd_issuer: RTL

Host-side command initiator for the pedometer core. Accepts step samples and weight-write requests from the host over valid/ready handshakes and drives the core's `countSteps`, `updateWeights` and `dualUpdateWeights` strobes with their operand buses (`A`, `B`, `Addr1`, `Data1`, `Addr2`, `Data2`). It buffers weight writes in a small FIFO, merges pairs into dual updates and enforces a minimum command spacing. It sits between the host bus and the pedometer top-level inputs.

---
 rtl/pedo_cmd_issuer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pedo_cmd_issuer.sv
// pedo_cmd_issuer: queues host samples and weight writes and issues paced command strobes to the pedometer core
module pedo_cmd_issuer #(
  parameter int WFIFO_DEPTH   = 4,
  parameter int ISSUE_GAP     = 3,
  parameter int COALESCE_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       smp_valid,
  output logic       smp_ready,
  input  logic [7:0] smp_a,
  input  logic [7:0] smp_b,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       countSteps,
  output logic       updateWeights,
  output logic       dualUpdateWeights,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] Addr1,
  output logic [7:0] Data1,
  output logic [2:0] Addr2,
  output logic [7:0] Data2,
  output logic       busy
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP);
  localparam logic [3:0] AGE_MIN = 4'(COALESCE_WAIT);
  localparam logic [CW-1:0] FULL = CW'(WFIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;
  typedef enum logic [1:0] {NONE, DUAL, SINGLE, STEP} cmd_t;
  state_t state, state_nx;
  cmd_t cmd, kind;
  logic [2:0] mem_addr [WFIFO_DEPTH];
  logic [7:0] mem_data [WFIFO_DEPTH];
  logic [PW-1:0] rd_ptr, rd_ptr2, wr_ptr;
  logic [CW-1:0] count, pop_n;
  logic [3:0] age, gap;
  logic smp_full, push, take;
  logic [7:0] hold_a, hold_b;
  assign smp_ready = reset && !smp_full;
  assign wr_ready = reset && count < FULL;
  assign push = wr_valid && wr_ready;
  assign take = smp_valid && smp_ready;
  assign rd_ptr2 = rd_ptr + PW'(1);
  assign busy = gap != 4'd0 || smp_full || count != '0;
  assign countSteps = state == STROBE && kind == STEP;
  assign updateWeights = state == STROBE && kind == SINGLE;
  assign dualUpdateWeights = state == STROBE && kind == DUAL;
  // Pick the command for this edge (weights outrank samples) and the FSM successor
  always_comb begin
    cmd = gap != 4'd0 ? NONE :
          count >= CW'(2) ? (mem_addr[rd_ptr] != mem_addr[rd_ptr2] ? DUAL : SINGLE) :
          (count == CW'(1) && age >= AGE_MIN) ? SINGLE :
          smp_full ? STEP : NONE;
    pop_n = cmd == DUAL ? CW'(2) : cmd == SINGLE ? CW'(1) : '0;
    state_nx = cmd != NONE ? STROBE : gap > 4'd1 ? GAP : IDLE;
  end
  // FSM state and the kind of command currently being strobed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      kind <= NONE;
    end else begin
      state <= state_nx;
      kind <= cmd;
    end
  end
  // Weight FIFO storage; only valid entries are ever read, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= wr_addr;
      mem_data[wr_ptr] <= wr_data;
    end
  end
  // FIFO bookkeeping, lone-entry age, issue spacing and the sample holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      age <= '0;
      gap <= '0;
      smp_full <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count <= count + CW'(push) - pop_n;
      age <= (count == CW'(1) && pop_n == '0) ? age + 4'(age != 4'hF) : '0;
      gap <= cmd != NONE ? GAP_LOAD : gap - 4'(gap != 4'd0);
      smp_full <= take || (smp_full && cmd != STEP);
      if (take) begin
        hold_a <= smp_a;
        hold_b <= smp_b;
      end
    end
  end
  // Operand registers change only on an issue edge; slot 1 always gets the older entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A <= '0;
      B <= '0;
      Addr1 <= '0;
      Data1 <= '0;
      Addr2 <= '0;
      Data2 <= '0;
    end else begin
      if (cmd == STEP) begin
        A <= hold_a;
        B <= hold_b;
      end
      if (cmd == DUAL || cmd == SINGLE) begin
        Addr1 <= mem_addr[rd_ptr];
        Data1 <= mem_data[rd_ptr];
      end
      if (cmd == DUAL) begin
        Addr2 <= mem_addr[rd_ptr2];
        Data2 <= mem_data[rd_ptr2];
      end
    end
  end
endmodule
